ips2l_pcie_dma_rx_mwr_wr_ctrl: RTL and testbench
================================================

// Module: ips2l_pcie_dma_rx_mwr_wr_ctrl
// PURPOSE
//  RX-side BAR RAM writer: takes the payload of a received memory-write TLP (header fields + packed 128-bit beats)
//  and writes it into the 128-bit BAR RAM at the TLP address, realigning DWs to addr[3:2], applying first/last BE.
//  Write-direction counterpart of the TX completion read controller; sits between RX TLP decode and BAR RAM write port.
// PARAMETERS
//  ADDR_WIDTH  9  BAR RAM word-address width (one word = 128 bit = 4 DW)
// PORTS
//  clk              in   1    core clock (gen1 62.5MHz, gen2 125MHz); one clock; reset is asynchronous and active-high
//  rst              in   1    asynchronous reset, active-high
//  i_wr_start       in   1    1-cycle pulse: new MWr, header fields valid this cycle
//  i_wr_length      in   10   payload length in DW; 0 encodes 1024
//  i_wr_addr        in   64   byte address (bits [1:0] ignored)
//  i_wr_first_be    in   4    first-DW byte enables
//  i_wr_last_be     in   4    last-DW byte enables (ignored when length==1)
//  i_wr_data        in   128  payload beat, DW0 in [31:0], packed from lane 0
//  i_wr_data_vld    in   1    beat valid
//  o_wr_data_rdy    out  1    beat accepted when vld&rdy
//  o_wr_busy        out  1    transfer in progress; i_wr_start ignored while high
//  o_wr_done        out  1    1-cycle pulse with the final RAM write
//  o_len_err        out  1    1-cycle pulse, length mismatch (see CONFIGURATION)
//  o_bar_wr_en      out  1    RAM write strobe
//  o_bar_wr_addr    out  ADDR_WIDTH  RAM word address
//  o_bar_wr_data    out  128  RAM write data
//  o_bar_wr_be      out  16   byte enables, bit 4*i+j = DW lane i byte j
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, carry/counters cleared. Reset mid-transfer aborts; no further RAM writes.
//  - FSM IDLE->DATA on i_wr_start (latch len, off=addr[3:2], word=addr[ADDR_WIDTH+3:4], BEs; len 0 -> 1024).
//    DATA: rdy=1; each accepted beat consumes min(4,remaining) DW. After last beat: if off+len spans more
//    RAM words than input beats (((off+len-1)>>2) > ((len-1)>>2)) -> FLUSH, else -> IDLE.
//    FLUSH: rdy=0, write carried DWs as final word, -> IDLE. rdy=0 in IDLE/FLUSH.
//  - Realignment: RAM word n lanes = {beat n lanes [3-off:0] shifted up by off, carry of beat n-1 top off lanes}.
//    off=0: pure pass-through, no carry, never FLUSH.
//  - Write latency: o_bar_wr_* registered, 1 cycle after the accepting beat (or FLUSH state); one write per beat.
//  - BE: lanes before first DW / after last DW = 0; first DW lane = first_be; last DW lane = last_be; inner = 4'hF.
//    len==1: only first_be used. first_be==0 still issues the write with BE 0 (zero-length write).
//  - Word address increments per write, wraps modulo 2^ADDR_WIDTH (no saturation).
//  - DW counter 11 bits; o_wr_busy = (state!=IDLE) | pending output write; o_wr_done coincides with final o_bar_wr_en.
//  - i_wr_start in same cycle as o_wr_done: ignored (busy still high); source must wait for busy low.
//  - i_wr_data_vld gaps allowed in DATA; no write issued on idle cycles.
// CONFIGURATION
//  IPS2L_PCIE_DMA_MWR_LEN_CHK_EN defined: tracks i_wr_data_vld beats vs length; a beat arriving in IDLE/FLUSH
//    pulses o_len_err and is dropped (no write); stalled DATA (no vld for 1024 cycles) pulses o_len_err, -> IDLE.
//  Not defined: no check, o_len_err tied 0, beats outside DATA ignored silently.
// STRUCTURE
//  Shared package ips2l_pcie_dma_pkg: FSM state encoding (IDLE/DATA/FLUSH), DW_PER_WORD=4, MAX_LEN_DW=1024.
//  Sub-module ips2l_pcie_dma_be_gen: combinational lane BE builder (off, dw_first, dw_last, first_be, last_be -> 16b).
//  Realign/carry register and FSM stay in this module.
// TESTING
//  1. addr=0x100, len=4, fbe=F, lbe=F -> one write, wr_addr=0x10, be=16'hFFFF, data=beat, done pulse same cycle.
//  2. addr=0x104, len=4, fbe=F, lbe=3 -> 2 writes: word 0x10 be=16'hFFF0 lanes1-3=DW0-2; word 0x11 (FLUSH) be=16'h0003 lane0=DW3.
//  3. addr=0x1C, len=1, fbe=6 -> one write word 0x01, be=16'h6000; lbe ignored; no FLUSH.
//  4. ADDR_WIDTH=9, addr=0x1FF0, len=8, off=0 -> writes at 0x1FF then 0x000 (wrap), both be=16'hFFFF.
//  5. len=0 (1024 DW), addr=0x8, vld toggling 50% -> 257 writes, carry correct, done on last, rdy low only in FLUSH.
//  6. rst asserted mid-DATA of len=16 -> outputs 0 next edge, no further writes; with _EN, stray beat in IDLE -> o_len_err=1, no write.

Source files
------------

// File: rtl/ips2l_pcie_dma_pkg.sv
// Shared definitions for the PCIe DMA BAR RAM datapath.
//   wr_state_e : write controller FSM encoding (IDLE / DATA / FLUSH)
//   beat_dw    : DWs consumed by one 128-bit beat given the DWs remaining
//   realign    : build a RAM word from the current beat and the previous beat's carry lanes
package ips2l_pcie_dma_pkg;

  localparam int unsigned DW_PER_WORD = 4;
  localparam int unsigned MAX_LEN_DW  = 1024;
  localparam int unsigned DW_CNT_W    = 11;
  localparam int unsigned DATA_W      = 128;
  localparam int unsigned BE_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FLUSH = 2'd2
  } wr_state_e;

  // Number of DWs carried by the next beat: min(DW_PER_WORD, remaining).
  function automatic logic [2:0] beat_dw(input logic [DW_CNT_W-1:0] rem);
    logic [2:0] n;
    if (rem >= DW_CNT_W'(DW_PER_WORD)) n = 3'(DW_PER_WORD);
    else                               n = rem[2:0];
    return n;
  endfunction

  // Lanes [off-1:0] come from the top lanes of lo (previous beat), the rest from hi shifted up by off.
  function automatic logic [DATA_W-1:0] realign(input logic [DATA_W-1:0] hi,
                                                input logic [DATA_W-1:0] lo,
                                                input logic [1:0]        off);
    logic [DATA_W-1:0] res;
    case (off)
      2'd1:    res = {hi[95:0], lo[127:96]};
      2'd2:    res = {hi[63:0], lo[127:64]};
      2'd3:    res = {hi[31:0], lo[127:32]};
      default: res = hi;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ips2l_pcie_dma_be_gen.sv
// Combinational lane byte-enable builder for one 128-bit BAR RAM word.
//   i_off       : lane of the first payload DW (only meaningful when i_dw_first)
//   i_dw_first  : this word holds the first payload DW
//   i_dw_last   : this word holds the last payload DW
//   i_last_lane : lane of the last payload DW (only meaningful when i_dw_last)
//   i_single    : payload is exactly one DW, so last_be is ignored
//   i_first_be  : byte enables of the first DW
//   i_last_be   : byte enables of the last DW
//   o_be_c      : 16-bit byte enables, bit 4*lane+byte
module ips2l_pcie_dma_be_gen
  import ips2l_pcie_dma_pkg::*;
(
  input  logic [1:0]      i_off,
  input  logic            i_dw_first,
  input  logic            i_dw_last,
  input  logic [1:0]      i_last_lane,
  input  logic            i_single,
  input  logic [3:0]      i_first_be,
  input  logic [3:0]      i_last_be,
  output logic [BE_W-1:0] o_be_c
);

  logic [3:0] lane_be;

  // Lanes outside [first, last] are blanked; first_be is applied last so it wins for one-DW payloads.
  always_comb begin
    o_be_c  = '0;
    lane_be = 4'h0;
    for (int i = 0; i < 4; i++) begin
      lane_be = 4'hF;
      if (i_dw_first && (2'(i) < i_off))                   lane_be = 4'h0;
      if (i_dw_last && (2'(i) > i_last_lane))              lane_be = 4'h0;
      if (i_dw_last && (2'(i) == i_last_lane) && !i_single) lane_be = i_last_be;
      if (i_dw_first && (2'(i) == i_off))                  lane_be = i_first_be;
      o_be_c[4*i +: 4] = lane_be;
    end
  end

endmodule

// File: rtl/ips2l_pcie_dma_rx_mwr_wr_ctrl.sv
// RX memory-write TLP payload to BAR RAM writer. Realigns packed payload DWs to the
// target lane given by addr[3:2], applies first/last byte enables, and issues one
// registered RAM write per accepted beat plus an optional trailing FLUSH write.
// Optional feature macro: IPS2L_PCIE_DMA_MWR_LEN_CHK_EN (stray-beat / stall detection on o_len_err).
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   i_wr_start            : header strobe; i_wr_length/addr/first_be/last_be valid
//   i_wr_data/_vld        : packed payload beats; o_wr_data_rdy accepts
//   o_wr_busy/o_wr_done   : transfer in progress / final write pulse
//   o_len_err             : length-check error pulse (0 unless the macro is defined)
//   o_bar_wr_en/addr/data/be : BAR RAM write port
module ips2l_pcie_dma_rx_mwr_wr_ctrl
  import ips2l_pcie_dma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_start,
  input  logic [9:0]            i_wr_length,
  input  logic [63:0]           i_wr_addr,
  input  logic [3:0]            i_wr_first_be,
  input  logic [3:0]            i_wr_last_be,
  input  logic [DATA_W-1:0]     i_wr_data,
  input  logic                  i_wr_data_vld,
  output logic                  o_wr_data_rdy,
  output logic                  o_wr_busy,
  output logic                  o_wr_done,
  output logic                  o_len_err,
  output logic                  o_bar_wr_en,
  output logic [ADDR_WIDTH-1:0] o_bar_wr_addr,
  output logic [DATA_W-1:0]     o_bar_wr_data,
  output logic [BE_W-1:0]       o_bar_wr_be
);

  wr_state_e             state_q, state_d;
  logic [DW_CNT_W-1:0]   rem_q, rem_d;
  logic [1:0]            off_q, off_d;
  logic [1:0]            last_lane_q, last_lane_d;
  logic                  single_q, single_d;
  logic                  need_flush_q, need_flush_d;
  logic                  first_q, first_d;
  logic [3:0]            fbe_q, fbe_d;
  logic [3:0]            lbe_q, lbe_d;
  logic [ADDR_WIDTH-1:0] word_q, word_d;
  logic [DATA_W-1:0]     prev_q, prev_d;
  logic                  rdy_q, rdy_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic [BE_W-1:0]       wr_be_q, wr_be_d;

  logic [DW_CNT_W-1:0]   start_len_c;
  logic [DW_CNT_W:0]     end_pos_c;
  logic                  start_flush_c;
  logic                  accept_c;
  logic                  last_beat_c;
  logic                  be_last_c;
  logic [BE_W-1:0]       be_c;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{i_wr_addr[63:ADDR_WIDTH+4], i_wr_addr[1:0]};

`ifdef IPS2L_PCIE_DMA_MWR_LEN_CHK_EN
  localparam int unsigned STALL_W = 10;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               len_err_q, len_err_d;
`endif

  // Header decode: a FLUSH is needed when the payload spans more RAM words than input beats.
  always_comb begin
    start_len_c   = (i_wr_length == 10'd0) ? DW_CNT_W'(MAX_LEN_DW) : DW_CNT_W'(i_wr_length);
    end_pos_c     = (DW_CNT_W+1)'(i_wr_addr[3:2]) + (DW_CNT_W+1)'(start_len_c) - (DW_CNT_W+1)'(1);
    start_flush_c = (end_pos_c >> 2) > ((DW_CNT_W+1)'(start_len_c - DW_CNT_W'(1)) >> 2);
  end

  assign accept_c    = rdy_q & i_wr_data_vld;
  assign last_beat_c = rem_q <= DW_CNT_W'(DW_PER_WORD);
  assign be_last_c   = (state_q == ST_FLUSH) | (last_beat_c & ~need_flush_q);

  ips2l_pcie_dma_be_gen u_be_gen (
    .i_off       (off_q),
    .i_dw_first  (first_q),
    .i_dw_last   (be_last_c),
    .i_last_lane (last_lane_q),
    .i_single    (single_q),
    .i_first_be  (fbe_q),
    .i_last_be   (lbe_q),
    .o_be_c      (be_c)
  );

  // Next-state and write-port logic.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    off_d        = off_q;
    last_lane_d  = last_lane_q;
    single_d     = single_q;
    need_flush_d = need_flush_q;
    first_d      = first_q;
    fbe_d        = fbe_q;
    lbe_d        = lbe_q;
    word_d       = word_q;
    prev_d       = prev_q;
    wr_en_d      = 1'b0;
    done_d       = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_be_d      = wr_be_q;
`ifdef IPS2L_PCIE_DMA_MWR_LEN_CHK_EN
    stall_d      = stall_q;
    len_err_d    = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        // busy_q still high during the final write cycle, so a start there is ignored.
        if (i_wr_start && !busy_q) begin
          state_d      = ST_DATA;
          rem_d        = start_len_c;
          off_d        = i_wr_addr[3:2];
          last_lane_d  = end_pos_c[1:0];
          single_d     = (start_len_c == DW_CNT_W'(1));
          need_flush_d = start_flush_c;
          first_d      = 1'b1;
          fbe_d        = i_wr_first_be;
          lbe_d        = i_wr_last_be;
          word_d       = i_wr_addr[ADDR_WIDTH+3:4];
          prev_d       = '0;
        end
`ifdef IPS2L_PCIE_DMA_MWR_LEN_CHK_EN
        stall_d   = '0;
        len_err_d = i_wr_data_vld;
`endif
      end

      ST_DATA: begin
        if (accept_c) begin
          wr_en_d   = 1'b1;
          wr_addr_d = word_q;
          wr_data_d = realign(i_wr_data, prev_q, off_q);
          wr_be_d   = be_c;
          word_d    = word_q + ADDR_WIDTH'(1);
          prev_d    = i_wr_data;
          first_d   = 1'b0;
          rem_d     = rem_q - DW_CNT_W'(beat_dw(rem_q));
          if (last_beat_c) begin
            done_d  = ~need_flush_q;
            state_d = need_flush_q ? ST_FLUSH : ST_IDLE;
          end
        end
`ifdef IPS2L_PCIE_DMA_MWR_LEN_CHK_EN
        // A source that stops delivering beats for too long is abandoned.
        if (accept_c) begin
          stall_d = '0;
        end else if (stall_q == '1) begin
          len_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
`endif
      end

      ST_FLUSH: begin
        // Carried top lanes of the last beat form the final word.
        wr_en_d   = 1'b1;
        done_d    = 1'b1;
        wr_addr_d = word_q;
        wr_data_d = realign('0, prev_q, off_q);
        wr_be_d   = be_c;
        word_d    = word_q + ADDR_WIDTH'(1);
        state_d   = ST_IDLE;
`ifdef IPS2L_PCIE_DMA_MWR_LEN_CHK_EN
        len_err_d = i_wr_data_vld;
`endif
      end

      default: state_d = ST_IDLE;
    endcase

    rdy_d  = (state_d == ST_DATA);
    busy_d = (state_d != ST_IDLE) | wr_en_d;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      off_q        <= '0;
      last_lane_q  <= '0;
      single_q     <= 1'b0;
      need_flush_q <= 1'b0;
      first_q      <= 1'b0;
      fbe_q        <= '0;
      lbe_q        <= '0;
      word_q       <= '0;
      prev_q       <= '0;
      rdy_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_be_q      <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      off_q        <= off_d;
      last_lane_q  <= last_lane_d;
      single_q     <= single_d;
      need_flush_q <= need_flush_d;
      first_q      <= first_d;
      fbe_q        <= fbe_d;
      lbe_q        <= lbe_d;
      word_q       <= word_d;
      prev_q       <= prev_d;
      rdy_q        <= rdy_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_be_q      <= wr_be_d;
    end
  end

`ifdef IPS2L_PCIE_DMA_MWR_LEN_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q   <= '0;
      len_err_q <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      len_err_q <= len_err_d;
    end
  end
  assign o_len_err = len_err_q;
`else
  assign o_len_err = 1'b0;
`endif

  assign o_wr_data_rdy = rdy_q;
  assign o_wr_busy     = busy_q;
  assign o_wr_done     = done_q;
  assign o_bar_wr_en   = wr_en_q;
  assign o_bar_wr_addr = wr_addr_q;
  assign o_bar_wr_data = wr_data_q;
  assign o_bar_wr_be   = wr_be_q;

endmodule

// File: tb/tb_ips2l_pcie_dma_rx_mwr_wr_ctrl.sv
// Self-checking bench for ips2l_pcie_dma_rx_mwr_wr_ctrl (ADDR_WIDTH=9).
// Expected RAM writes are derived per DW: DW d of the payload lands in word
// (addr>>4)+((off+d)>>2), lane (off+d)&3.
module tb_ips2l_pcie_dma_rx_mwr_wr_ctrl;

  localparam int unsigned AW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_wr_start;
  logic [9:0]    i_wr_length;
  logic [63:0]   i_wr_addr;
  logic [3:0]    i_wr_first_be;
  logic [3:0]    i_wr_last_be;
  logic [127:0]  i_wr_data;
  logic          i_wr_data_vld;
  logic          o_wr_data_rdy;
  logic          o_wr_busy;
  logic          o_wr_done;
  logic          o_len_err;
  logic          o_bar_wr_en;
  logic [AW-1:0] o_bar_wr_addr;
  logic [127:0]  o_bar_wr_data;
  logic [15:0]   o_bar_wr_be;

  always #5 clk = ~clk;

  ips2l_pcie_dma_rx_mwr_wr_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_wr_start    (i_wr_start),
    .i_wr_length   (i_wr_length),
    .i_wr_addr     (i_wr_addr),
    .i_wr_first_be (i_wr_first_be),
    .i_wr_last_be  (i_wr_last_be),
    .i_wr_data     (i_wr_data),
    .i_wr_data_vld (i_wr_data_vld),
    .o_wr_data_rdy (o_wr_data_rdy),
    .o_wr_busy     (o_wr_busy),
    .o_wr_done     (o_wr_done),
    .o_len_err     (o_len_err),
    .o_bar_wr_en   (o_bar_wr_en),
    .o_bar_wr_addr (o_bar_wr_addr),
    .o_bar_wr_data (o_bar_wr_data),
    .o_bar_wr_be   (o_bar_wr_be)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [127:0]  data;
    logic [127:0]  mask;
    logic [15:0]   be;
    logic          done;
  } wr_t;

  wr_t         got_q[$];
  wr_t         exp_q[$];
  int          len_err_cnt = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] dw [0:1023];

  // Record every RAM write one step after the clock edge.
  always @(posedge clk) begin
    #1;
    if (o_bar_wr_en)
      got_q.push_back('{addr: o_bar_wr_addr, data: o_bar_wr_data, mask: '0,
                        be: o_bar_wr_be, done: o_wr_done});
    if (o_len_err) len_err_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected writes computed DW by DW from the payload.
  task automatic build_model(input logic [63:0] addr, input int len, input logic [3:0] fbe,
                             input logic [3:0] lbe);
    int  off;
    int  nw;
    wr_t w;
    off = int'(addr[3:2]);
    nw  = (off + len - 1) / 4 + 1;
    exp_q.delete();
    for (int n = 0; n < nw; n++) begin
      w      = '0;
      w.addr = AW'((int'(addr[AW+3:4]) + n) % (1 << AW));
      w.done = (n == nw - 1);
      for (int i = 0; i < 4; i++) begin
        int d;
        d = 4 * n + i - off;
        if (d >= 0 && d < len) begin
          w.data[32*i +: 32] = dw[d];
          w.mask[32*i +: 32] = 32'hFFFF_FFFF;
          if (d == 0)            w.be[4*i +: 4] = fbe;
          else if (d == len - 1) w.be[4*i +: 4] = lbe;
          else                   w.be[4*i +: 4] = 4'hF;
        end
      end
      exp_q.push_back(w);
    end
  endtask

  // mode 0: vld every cycle, 1: random 50%, 2: toggling
  task automatic run(input string tag, input logic [63:0] addr, input int len,
                     input logic [3:0] fbe, input logic [3:0] lbe, input int mode);
    int   nb;
    int   b;
    int   cyc;
    logic v;
    logic r;
    for (int d = 0; d < len; d++) dw[d] = $urandom;
    build_model(addr, len, fbe, lbe);
    nb = (len + 3) / 4;
    got_q.delete();
    i_wr_start    = 1'b1;
    i_wr_length   = 10'(len);
    i_wr_addr     = addr;
    i_wr_first_be = fbe;
    i_wr_last_be  = lbe;
    @(negedge clk);
    i_wr_start = 1'b0;
    b   = 0;
    cyc = 0;
    while (b < nb && cyc < 5000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = 1'($urandom_range(0, 1));
        default: v = (cyc % 2 == 0);
      endcase
      i_wr_data_vld = v;
      for (int k = 0; k < 4; k++)
        i_wr_data[32*k +: 32] = (4 * b + k < len) ? dw[4 * b + k] : $urandom;
      r = o_wr_data_rdy;
      @(posedge clk);
      if (v && r) b++;
      @(negedge clk);
      cyc++;
    end
    i_wr_data_vld = 1'b0;
    cyc = 0;
    while (o_wr_busy && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_beats"}, 128'(b), 128'(nb));
    chk({tag, "_idle"}, 128'(o_wr_busy), 128'(0));
    chk({tag, "_nwr"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int n = 0; n < exp_q.size(); n++) begin
      if (n < got_q.size()) begin
        chk($sformatf("%s_w%0d_addr", tag, n), 128'(got_q[n].addr), 128'(exp_q[n].addr));
        chk($sformatf("%s_w%0d_be", tag, n), 128'(got_q[n].be), 128'(exp_q[n].be));
        chk($sformatf("%s_w%0d_data", tag, n), got_q[n].data & exp_q[n].mask, exp_q[n].data);
        chk($sformatf("%s_w%0d_done", tag, n), 128'(got_q[n].done), 128'(exp_q[n].done));
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    i_wr_start    = 1'b0;
    i_wr_length   = '0;
    i_wr_addr     = '0;
    i_wr_first_be = '0;
    i_wr_last_be  = '0;
    i_wr_data     = '0;
    i_wr_data_vld = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("reset_ctrl", 128'({o_wr_data_rdy, o_wr_busy, o_wr_done, o_len_err, o_bar_wr_en}), 128'(0));
    chk("reset_port", {o_bar_wr_data ^ 128'(o_bar_wr_be) ^ 128'(o_bar_wr_addr)}, 128'(0));

    // Directed cases
    run("t1_aligned", 64'h100, 4, 4'hF, 4'hF, 0);
    chk("t1_be_literal", 128'(got_q.size() > 0 ? got_q[0].be : 16'h0), 128'(16'hFFFF));
    run("t2_flush", 64'h104, 4, 4'hF, 4'h3, 0);
    chk("t2_flush_be", 128'(got_q.size() > 1 ? got_q[1].be : 16'h0), 128'(16'h0003));
    run("t3_single", 64'h1C, 1, 4'h6, 4'hA, 0);
    chk("t3_be_literal", 128'(got_q.size() > 0 ? got_q[0].be : 16'h0), 128'(16'h6000));
    run("t4_wrap", 64'h1FF0, 8, 4'hF, 4'hF, 0);
    run("t5_len1024", 64'h8, 1024, 4'hC, 4'h7, 2);
    chk("t5_nwr_257", 128'(got_q.size()), 128'(257));
    run("t_zero_fbe", 64'h24, 1, 4'h0, 4'hF, 1);

    // Random transfers
    for (int t = 0; t < 12; t++) begin
      logic [63:0] a;
      a = {$urandom, $urandom};
      run($sformatf("rnd%0d", t), a, int'($urandom_range(1, 40)),
          4'($urandom), 4'($urandom), 1);
    end
    chk("no_len_err", 128'(len_err_cnt), 128'(0));

    // Reset in the middle of a 16-DW transfer
    for (int d = 0; d < 16; d++) dw[d] = $urandom;
    i_wr_start = 1'b1; i_wr_length = 10'd16; i_wr_addr = 64'h44;
    i_wr_first_be = 4'hF; i_wr_last_be = 4'hF;
    @(negedge clk);
    i_wr_start = 1'b0;
    i_wr_data_vld = 1'b1;
    i_wr_data = {dw[3], dw[2], dw[1], dw[0]};
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    got_q.delete();
    chk("t6_rst_ctrl", 128'({o_wr_data_rdy, o_wr_busy, o_wr_done, o_len_err, o_bar_wr_en}), 128'(0));
    chk("t6_rst_port", {o_bar_wr_data ^ 128'(o_bar_wr_be) ^ 128'(o_bar_wr_addr)}, 128'(0));
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_no_wr_after_rst", 128'(got_q.size()), 128'(0));
    chk("t6_idle_after_rst", 128'(o_wr_busy), 128'(0));

    // Stray beat in IDLE
    i_wr_data_vld = 1'b0;
    @(negedge clk);
    len_err_cnt = 0;
    got_q.delete();
    i_wr_data_vld = 1'b1;
    @(negedge clk);
    i_wr_data_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_stray_no_wr", 128'(got_q.size()), 128'(0));
`ifdef IPS2L_PCIE_DMA_MWR_LEN_CHK_EN
    chk("t6_stray_len_err", 128'(len_err_cnt), 128'(1));
`else
    chk("t6_stray_len_err", 128'(len_err_cnt), 128'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
